wb_ram_slave: RTL

- Wishbone B4 classic (non-pipelined) slave: block RAM of DATA_WIDTH-bit lines, sitting directly downstream of the cpu top's Wishbone master port.
- Consumes the cpu's wb_*_o outputs and produces its wb_*_i inputs.
- Configurable wait states; error response on out-of-range or misaligned addresses.
- Serves as the main instruction/data memory in simulation and FPGA builds.

---
 rtl/wb_ram_slave_if.sv | 27 ++
 rtl/wb_ram_slave.sv | 111 +++++++++++
 2 files changed

// File: rtl/wb_ram_slave_if.sv
// Wishbone B4 classic bus bundle between the cpu master port and the RAM slave.
// Signal names keep the slave-side suffixes so both ends read the same.
interface wb_ram_slave_if #(
    parameter int DATA_WIDTH = 128,
    parameter int SEL_WIDTH  = 4
);
    logic [31:0]           wb_adr_i;
    logic [DATA_WIDTH-1:0] wb_dat_i;
    logic [DATA_WIDTH-1:0] wb_dat_o;
    logic                  wb_we_i;
    logic [SEL_WIDTH-1:0]  wb_sel_i;
    logic                  wb_stb_i;
    logic                  wb_cyc_i;
    logic                  wb_ack_o;
    logic                  wb_err_o;
    logic                  wb_rty_o;

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
        output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
    );

    modport master (
        output wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
        input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
    );
endinterface

// File: rtl/wb_ram_slave.sv
// Wishbone B4 classic block-RAM slave with programmable wait states and an
// error termination for out-of-range or misaligned line addresses.
module wb_ram_slave #(
    parameter int          DATA_WIDTH  = 128,
    parameter int          GRANULARITY = 32,
    parameter int          DEPTH_LOG2  = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 1,
    parameter string       INIT_FILE   = ""
) (
    input logic            clk,
    input logic            rst,
    wb_ram_slave_if.slave  bus
);
    localparam int          SEL_WIDTH = DATA_WIDTH / GRANULARITY;
    localparam int          LB        = DATA_WIDTH / 8;
    localparam int          OFF_BITS  = $clog2(LB);
    localparam int          DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [63:0] SPAN      = 64'(LB) << DEPTH_LOG2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK,
        S_ERR
    } state_t;

    state_t                  r_state;
    state_t                  w_nextState;
    logic [3:0]              r_waitCnt;
    logic [3:0]              w_nextCnt;
    logic [DATA_WIDTH-1:0]   r_datOut;
    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

    logic [31:0]             w_off;
    logic [DEPTH_LOG2-1:0]   w_lineIdx;
    logic                    w_inRange;
    logic                    w_aligned;
    logic                    w_valid;
    logic                    w_req;
    logic                    w_enterAck;

    // Line size is a power of two, so index and alignment are plain bit fields of the offset.
    assign w_off      = bus.wb_adr_i - BASE_ADDR;
    assign w_lineIdx  = w_off[OFF_BITS +: DEPTH_LOG2];
    assign w_inRange  = (bus.wb_adr_i >= BASE_ADDR) && ({32'd0, w_off} < SPAN);
    assign w_aligned  = (w_off[OFF_BITS-1:0] == '0);
    assign w_valid    = w_inRange && w_aligned;
    assign w_req      = bus.wb_cyc_i && bus.wb_stb_i;
    assign w_enterAck = (w_nextState == S_ACK);

    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_waitCnt;
        unique case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (!w_valid) begin
                        w_nextState = S_ERR;
                    end else if (WAIT_STATES == 0) begin
                        w_nextState = S_ACK;
                    end else begin
                        w_nextState = S_WAIT;
                        w_nextCnt   = 4'(WAIT_STATES - 1);
                    end
                end
            end
            S_WAIT: begin
                if (!w_req) begin
                    w_nextState = S_IDLE;
                    w_nextCnt   = '0;
                end else if (r_waitCnt == 4'd0) begin
                    w_nextState = S_ACK;
                end else begin
                    w_nextCnt = r_waitCnt - 4'd1;
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_waitCnt <= '0;
            r_datOut  <= '0;
        end else begin
            r_state   <= w_nextState;
            r_waitCnt <= w_nextCnt;
            r_datOut  <= (w_enterAck && !bus.wb_we_i) ? r_mem[w_lineIdx] : '0;
        end
    end

    // The RAM has no reset; an edge seen while rst is high must not commit a write.
    always_ff @(posedge clk) begin
        if (w_enterAck && bus.wb_we_i && !rst) begin
            for (int k = 0; k < SEL_WIDTH; k++) begin
                if (bus.wb_sel_i[k]) begin
                    r_mem[w_lineIdx][k*GRANULARITY +: GRANULARITY] <= bus.wb_dat_i[k*GRANULARITY +: GRANULARITY];
                end
            end
        end
    end

    assign bus.wb_ack_o = (r_state == S_ACK);
    assign bus.wb_err_o = (r_state == S_ERR);
    assign bus.wb_dat_o = r_datOut;
    assign bus.wb_rty_o = 1'b0;
endmodule
